spiflash_reader: RTL and testbench
==================================

Name: spiflash_reader

Overview:
- Synthesizable SPI flash read initiator (SPI mode 0, single-bit I/O). It drives the same four flash pins that the board-level spiflash responder model serves.
- Accepts a 24-bit byte address over a valid/ready request port. Issues a READ (0x03) transaction, shifts in 4 bytes and returns them as one 32-bit little-endian word.
- Sits between the management core's boot/fetch logic and the flash_csb/flash_clk/flash_io0/flash_io1 pads.

Parameters:
- CLK_DIV, 2, system-clock cycles per flash_clk half-period; legal range 1..255.
- CSB_IDLE, 2, minimum cycles flash_csb stays high between transactions; legal range 1..15.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetb  input  1  asynchronous active-low reset.
- req_valid  input  1  read request.
- req_ready  output  1  block idle and able to accept.
- req_addr  input  24  flash byte address; captured on accept.
- rsp_valid  output  1  one-cycle pulse; rsp_data is valid.
- rsp_data  output  32  read word; first byte received is in [7:0].
- busy  output  1  high from accept until req_ready reasserts.
- flash_csb  output  1  chip select, active low.
- flash_clk  output  1  SPI clock; idle low.
- flash_io0  output  1  MOSI.
- flash_io1  input  1  MISO.

Behaviour:
- Reset values: flash_csb=1, flash_clk=0, flash_io0=0, req_ready=1, rsp_valid=0, rsp_data=0, busy=0. State is IDLE.
- Accept: a request is accepted in the cycle where req_valid && req_ready. In that cycle req_addr is latched and the 32-bit TX shift register is loaded with {8'h03, req_addr}. The following cycle has req_ready=0 and busy=1.
- FSM states: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> [DUMMY] -> DATA (32 bits) -> DONE -> GAP -> IDLE.
- Bit timing:
  - Each bit is one flash_clk period: CLK_DIV cycles low, then CLK_DIV cycles high.
  - flash_io0 is updated only while flash_clk is low, at the start of the low half. The MSB is sent first.
  - flash_io1 is sampled in the cycle flash_clk rises, MSB of each byte first.
  - A bit counter and a half-period counter (8 bits) drive the sequencing.
- CSB timing: flash_csb falls in cycle T+1 (T = accept cycle), together with the first low half.
- DATA phase:
  - Bytes are assembled little-endian: byte0 goes to [7:0], byte1 to [15:8], byte2 to [23:16], byte3 to [31:24].
  - flash_io0 is driven 0 for the whole phase.
- DONE:
  - Entered after the high half of the 64th bit completes.
  - In that cycle flash_clk=0 and flash_csb=1.
  - rsp_valid pulses for exactly 1 cycle with rsp_data updated in the same cycle.
  - rsp_valid occurs at T+1+128*CLK_DIV (T+257 at default).
  - rsp_data holds its value until the next response.
- GAP:
  - flash_csb stays high for CSB_IDLE cycles after DONE, then the FSM returns to IDLE.
  - req_ready=1 and busy=0 in cycle T+2+128*CLK_DIV+CSB_IDLE.
- There is no response backpressure. A req_valid held high after a response starts the next transaction as soon as req_ready rises (back-to-back, gap enforced).
- req_valid while busy is ignored and is not queued. req_addr changes after accept have no effect.
- Address wrap: 24'hFFFFFF is sent verbatim. Byte wrap is the flash's concern.
- Reset mid-transaction: flash_csb goes to 1 and flash_clk to 0 immediately (asynchronously). No rsp_valid is generated. The block is in IDLE with req_ready=1 after reset deasserts.
- Every output is registered, so flash pins are glitch-free.

Optional Feature:
- SPIFLASH_FAST_READ_EN defined:
  - The command byte is 0x0B.
  - A DUMMY state of 8 flash_clk periods (io0=0, io1 ignored) is inserted between ADDR and DATA.
  - rsp_valid occurs at T+1+144*CLK_DIV.
- Not defined: the command byte is 0x03, the DUMMY state does not exist, and the timing is as in Behaviour.

Test Plan:
- Reset, CLK_DIV=2, responder bytes 0x6F,0x00,0x00,0x0B at addr 0. Request addr 0x000000. Required:
  - flash_csb falls at T+1.
  - io0 stream is 0x03,0x00,0x00,0x00.
  - rsp_valid at T+257 with rsp_data=32'h0B00006F.
  - req_ready at T+260.
- Two back-to-back requests, addr 0x000004 then 0x100010, with req_valid held high. Required:
  - Two responses carry the correct words.
  - flash_csb stays high for at least 2 cycles between them.
  - Second address bits on io0 are 0x10,0x00,0x10.
- CLK_DIV=1, addr 0xFFFFFC. Required:
  - rsp_valid at T+129.
  - flash_clk period is 2 cycles with 50% duty.
  - Address sent as 0xFF,0xFF,0xFC.
- Assert resetb=0 during ADDR bit 10. Required:
  - flash_csb=1 and flash_clk=0 in the same cycle.
  - No rsp_valid.
  - After release, req_ready=1 and a fresh request completes correctly.
- Pulse req_valid with addr 0x000200 while busy. Required: the pulse is ignored, there is exactly one response, and the address on the wire is the originally accepted one.
- With SPIFLASH_FAST_READ_EN, addr 0x000000. Required:
  - Command byte is 0x0B.
  - 8 dummy clocks follow the address.
  - rsp_valid at T+289 with rsp_data=32'h0B00006F.

Source files
------------

// File: rtl/spiflash_reader.sv
// SPI mode-0, single-bit flash read initiator: one 24-bit address in, one little-endian 32-bit word out.
// Define SPIFLASH_FAST_READ_EN to issue FAST_READ (0x0B) with 8 dummy clocks instead of READ (0x03).
module spiflash_reader #(
  parameter int CLK_DIV  = 2,
  parameter int CSB_IDLE = 2
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

`ifdef SPIFLASH_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif
  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST  = 4'(CSB_IDLE - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  half_cnt_reg, half_cnt_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic [31:0] tx_sh_reg, tx_sh_next;
  logic [31:0] rx_word_reg, rx_word_next;
  logic        req_ready_reg, req_ready_next;
  logic        busy_reg, busy_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_data_reg, rsp_data_next;
  logic        csb_reg, csb_next;
  logic        fclk_reg, fclk_next;
  logic        io0_reg, io0_next;

  logic        shifting, half_end, rise, bit_end, phase_done, accept;
  logic [4:0]  phase_last_bit;

  always_comb begin
    shifting = (state_reg == CMD) || (state_reg == ADDR) ||
               (state_reg == DUMMY) || (state_reg == DATA);
    half_end = shifting && (half_cnt_reg == HALF_LAST);
    rise     = half_end && !fclk_reg;
    bit_end  = half_end && fclk_reg;
    accept   = (state_reg == IDLE) && req_valid && req_ready_reg;
    case (state_reg)
      CMD:     phase_last_bit = 5'd7;
      ADDR:    phase_last_bit = 5'd23;
      DUMMY:   phase_last_bit = 5'd7;
      default: phase_last_bit = 5'd31;
    endcase
    phase_done = bit_end && (bit_cnt_reg == phase_last_bit);
  end

  always_comb begin
    state_next     = state_reg;
    half_cnt_next  = half_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    tx_sh_next     = tx_sh_reg;
    rx_word_next   = rx_word_reg;
    req_ready_next = req_ready_reg;
    busy_next      = busy_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;
    csb_next       = csb_reg;
    fclk_next      = fclk_reg;
    io0_next       = io0_reg;

    if (shifting) begin
      half_cnt_next = half_end ? 8'd0 : half_cnt_reg + 8'd1;
      if (half_end) fclk_next = !fclk_reg;
    end

    // Bit i of the data phase lands in byte i/8, MSB-first within the byte.
    if (rise && state_reg == DATA)
      rx_word_next[{bit_cnt_reg[4:3], ~bit_cnt_reg[2:0]}] = flash_io1;

    // A bit ends at the falling edge; the next MOSI bit goes out with it.
    if (bit_end) begin
      tx_sh_next   = {tx_sh_reg[30:0], 1'b0};
      io0_next     = tx_sh_reg[30];
      bit_cnt_next = phase_done ? 5'd0 : bit_cnt_reg + 5'd1;
    end

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next     = CMD;
          tx_sh_next     = {READ_CMD, req_addr};
          io0_next       = READ_CMD[7];
          csb_next       = 1'b0;
          fclk_next      = 1'b0;
          half_cnt_next  = 8'd0;
          bit_cnt_next   = 5'd0;
          req_ready_next = 1'b0;
          busy_next      = 1'b1;
        end
      end
      CMD: begin
        if (phase_done) state_next = ADDR;
      end
      ADDR: begin
        if (phase_done) begin
`ifdef SPIFLASH_FAST_READ_EN
          state_next = DUMMY;
`else
          state_next = DATA;
`endif
          io0_next = 1'b0;
        end
      end
      DUMMY: begin
        io0_next = 1'b0;
        if (phase_done) state_next = DATA;
      end
      DATA: begin
        io0_next = 1'b0;
        if (phase_done) begin
          state_next     = DONE;
          csb_next       = 1'b1;
          fclk_next      = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_data_next  = rx_word_reg;
        end
      end
      DONE: begin
        state_next   = GAP;
        gap_cnt_next = 4'd0;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next     = IDLE;
          req_ready_next = 1'b1;
          busy_next      = 1'b0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_reg     <= IDLE;
      half_cnt_reg  <= 8'd0;
      bit_cnt_reg   <= 5'd0;
      gap_cnt_reg   <= 4'd0;
      tx_sh_reg     <= 32'd0;
      rx_word_reg   <= 32'd0;
      req_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 32'd0;
      csb_reg       <= 1'b1;
      fclk_reg      <= 1'b0;
      io0_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      half_cnt_reg  <= half_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      tx_sh_reg     <= tx_sh_next;
      rx_word_reg   <= rx_word_next;
      req_ready_reg <= req_ready_next;
      busy_reg      <= busy_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      csb_reg       <= csb_next;
      fclk_reg      <= fclk_next;
      io0_reg       <= io0_next;
    end
  end

  assign req_ready = req_ready_reg;
  assign busy      = busy_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign flash_csb = csb_reg;
  assign flash_clk = fclk_reg;
  assign flash_io0 = io0_reg;

endmodule

// File: tb/tb_spiflash_reader.sv
// Bench for spiflash_reader: unit 0 runs CLK_DIV=2, unit 1 runs CLK_DIV=1, each with a behavioural flash responder.
// Expected words come from a byte-addressed flash image; timings from the bit-count arithmetic.
module tb_spiflash_reader;
  localparam int CSB_IDLE = 2;
`ifdef SPIFLASH_FAST_READ_EN
  localparam logic [7:0] CMD_EXP = 8'h0B;
  localparam int HDR_BITS = 40;
`else
  localparam logic [7:0] CMD_EXP = 8'h03;
  localparam int HDR_BITS = 32;
`endif
  localparam int TXN_BITS = HDR_BITS + 32;

  logic        clock;
  logic        resetb;
  logic [1:0]  req_valid;
  logic [23:0] req_addr [2];
  wire  [1:0]  req_ready, rsp_valid, busy, flash_csb, flash_clk, flash_io0;
  wire  [31:0] rsp_data [2];
  logic [1:0]  flash_io1;

  int cyc;
  int n_cmp;
  int n_fail;
  int rsp_cnt [2];

  // Responder state per unit
  int          nbits [2];
  logic [71:0] mosi [2];
  logic [7:0]  cap_cmd [2];
  logic [23:0] cap_addr [2];
  logic [7:0]  cap_dummy [2];
  logic        data_io0 [2];

  logic [7:0] flash_mem [int];

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (flash_mem.exists(int'(a))) return flash_mem[int'(a)];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w = w | (32'(mem_byte(a + 24'(k))) << (8 * k));
    return w;
  endfunction

  function automatic int cd_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic int lat_of(input int u);
    return 1 + 2 * cd_of(u) * TXN_BITS;
  endfunction

  task automatic fill_random(input logic [23:0] a);
    for (int k = 0; k < 4; k++) flash_mem[int'(a + 24'(k))] = 8'($urandom);
  endtask

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    for (int i = 0; i < 2; i++)
      if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unit
    spiflash_reader #(.CLK_DIV(gi == 0 ? 2 : 1), .CSB_IDLE(CSB_IDLE)) dut (
      .clock(clock), .resetb(resetb),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_addr(req_addr[gi]),
      .rsp_valid(rsp_valid[gi]), .rsp_data(rsp_data[gi]), .busy(busy[gi]),
      .flash_csb(flash_csb[gi]), .flash_clk(flash_clk[gi]),
      .flash_io0(flash_io0[gi]), .flash_io1(flash_io1[gi])
    );

    always @(negedge flash_csb[gi]) begin
      nbits[gi] = 0;
      mosi[gi] = '0;
      data_io0[gi] = 1'b0;
    end

    always @(posedge flash_clk[gi]) begin
      if (flash_csb[gi] === 1'b0) begin
        mosi[gi] = {mosi[gi][70:0], flash_io0[gi]};
        nbits[gi] = nbits[gi] + 1;
        if (nbits[gi] == 32) begin
          cap_cmd[gi] = mosi[gi][31:24];
          cap_addr[gi] = mosi[gi][23:0];
        end
        if (nbits[gi] == 40) cap_dummy[gi] = mosi[gi][7:0];
        if (nbits[gi] > HDR_BITS) data_io0[gi] = data_io0[gi] | flash_io0[gi];
      end
    end

    // Mode 0: the flash shifts its next bit out on each falling edge after the header.
    always @(negedge flash_clk[gi]) begin
      if (flash_csb[gi] === 1'b0 && nbits[gi] >= HDR_BITS && nbits[gi] < TXN_BITS) begin
        int d;
        logic [7:0] b;
        d = nbits[gi] - HDR_BITS;
        b = mem_byte(cap_addr[gi] + 24'(d / 8));
        flash_io1[gi] = b[7 - (d % 8)];
      end
    end
  end

  task automatic issue(input int u, input logic [23:0] a, input bit hold, output int t_acc, output bit to);
    to = 1'b1;
    t_acc = -1;
    @(negedge clock);
    req_valid[u] = 1'b1;
    req_addr[u] = a;
    for (int n = 0; n < 2000; n++) begin
      if (req_ready[u] === 1'b1) begin
        t_acc = cyc;
        to = 1'b0;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    if (!hold) req_valid[u] = 1'b0;
    req_addr[u] = 24'($urandom);
  endtask

  task automatic wait_rsp(input int u, output int t, output logic [31:0] d, output bit to);
    to = 1'b1;
    t = -1;
    d = 'x;
    for (int n = 0; n < 4000; n++) begin
      if (rsp_valid[u] === 1'b1) begin
        t = cyc;
        d = rsp_data[u];
        to = 1'b0;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_ready(input int u, output int t, output bit to);
    to = 1'b1;
    t = -1;
    for (int n = 0; n < 4000; n++) begin
      if (req_ready[u] === 1'b1) begin
        t = cyc;
        to = 1'b0;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    req_valid = 2'b00;
    req_addr[0] = 24'd0;
    req_addr[1] = 24'd0;
    flash_io1 = 2'b00;
    repeat (3) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if ({flash_csb[u], flash_clk[u], flash_io0[u], req_ready[u], rsp_valid[u], busy[u]} !== 6'b100100) begin
        n_fail++;
        $display("FAIL reset_outputs u%0d: got %b want 100100", u,
                 {flash_csb[u], flash_clk[u], flash_io0[u], req_ready[u], rsp_valid[u], busy[u]});
      end
      n_cmp++;
      if (rsp_data[u] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_rsp_data u%0d: got %h want 00000000", u, rsp_data[u]);
      end
    end
    resetb = 1'b1;
    repeat (2) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if ({req_ready[u], busy[u], flash_csb[u]} !== 3'b101) begin
        n_fail++;
        $display("FAIL post_reset_idle u%0d: got %b want 101", u, {req_ready[u], busy[u], flash_csb[u]});
      end
    end
  endtask

  task automatic test_basic();
    int t, tr, trdy;
    bit to;
    logic [31:0] d;
    flash_mem[0] = 8'h6F;
    flash_mem[1] = 8'h00;
    flash_mem[2] = 8'h00;
    flash_mem[3] = 8'h0B;
    issue(0, 24'h000000, 1'b0, t, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL basic_accept: got timeout want accept"); end
    n_cmp++;
    if (flash_csb[0] !== 1'b0) begin n_fail++; $display("FAIL basic_csb_T1: got %b want 0", flash_csb[0]); end
    wait_rsp(0, tr, d, to);
    n_cmp++;
    if (to || (tr - t) != lat_of(0)) begin
      n_fail++; $display("FAIL basic_rsp_lat: got %0d want %0d", tr - t, lat_of(0));
    end
    n_cmp++;
    if (d !== 32'h0B00006F) begin n_fail++; $display("FAIL basic_data: got %h want 0B00006F", d); end
    n_cmp++;
    if ({cap_cmd[0], cap_addr[0]} !== {CMD_EXP, 24'h000000}) begin
      n_fail++; $display("FAIL basic_io0_stream: got %h want %h", {cap_cmd[0], cap_addr[0]}, {CMD_EXP, 24'h000000});
    end
    n_cmp++;
    if (nbits[0] != TXN_BITS || data_io0[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_clocks: got %0d/io0=%b want %0d/io0=0", nbits[0], data_io0[0], TXN_BITS);
    end
`ifdef SPIFLASH_FAST_READ_EN
    n_cmp++;
    if (cap_dummy[0] !== 8'h00) begin n_fail++; $display("FAIL basic_dummy_io0: got %h want 00", cap_dummy[0]); end
`endif
    @(negedge clock);
    n_cmp++;
    if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_rsp_pulse: got %b want 0", rsp_valid[0]); end
    wait_ready(0, trdy, to);
    n_cmp++;
    if (to || (trdy - t) != lat_of(0) + 1 + CSB_IDLE) begin
      n_fail++; $display("FAIL basic_ready_lat: got %0d want %0d", trdy - t, lat_of(0) + 1 + CSB_IDLE);
    end
    $display("txn basic u0 addr=000000 data=%h lat=%0d ready=%0d", d, tr - t, trdy - t);
  endtask

  task automatic test_back_to_back();
    int t1, r1, r2, trdy, hi;
    bit to;
    logic [31:0] d1, d2;
    fill_random(24'h000004);
    fill_random(24'h100010);
    issue(0, 24'h000004, 1'b1, t1, to);
    req_addr[0] = 24'h100010;
    wait_rsp(0, r1, d1, to);
    n_cmp++;
    if (to || d1 !== exp_word(24'h000004) || cap_addr[0] !== 24'h000004) begin
      n_fail++; $display("FAIL b2b_first: got %h@%h want %h@000004", d1, cap_addr[0], exp_word(24'h000004));
    end
    hi = 0;
    for (int n = 0; n < 50; n++) begin
      if (flash_csb[0] !== 1'b1) break;
      hi++;
      @(negedge clock);
    end
    req_valid[0] = 1'b0;
    n_cmp++;
    if (hi != 2 + CSB_IDLE) begin n_fail++; $display("FAIL b2b_csb_gap: got %0d want %0d", hi, 2 + CSB_IDLE); end
    wait_rsp(0, r2, d2, to);
    n_cmp++;
    if (to || d2 !== exp_word(24'h100010)) begin
      n_fail++; $display("FAIL b2b_second_data: got %h want %h", d2, exp_word(24'h100010));
    end
    n_cmp++;
    if (cap_addr[0] !== 24'h100010) begin
      n_fail++; $display("FAIL b2b_second_addr: got %h want 100010", cap_addr[0]);
    end
    n_cmp++;
    if ((r2 - r1) != lat_of(0) + 1 + CSB_IDLE) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", r2 - r1, lat_of(0) + 1 + CSB_IDLE);
    end
    wait_ready(0, trdy, to);
    $display("txn b2b u0 addr=000004 data=%h", d1);
    $display("txn b2b u0 addr=100010 data=%h", d2);
  endtask

  task automatic test_clk_div1();
    int t, tr, trdy, bad;
    bit to;
    logic [31:0] d;
    fill_random(24'hFFFFFC);
    issue(1, 24'hFFFFFC, 1'b0, t, to);
    bad = 0;
    for (int k = 0; k < 2 * TXN_BITS; k++) begin
      if (flash_clk[1] !== 1'(k % 2) || flash_csb[1] !== 1'b0) bad++;
      @(negedge clock);
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL div1_clk_shape: got %0d bad cycles want 0", bad); end
    wait_rsp(1, tr, d, to);
    n_cmp++;
    if (to || (tr - t) != lat_of(1)) begin
      n_fail++; $display("FAIL div1_rsp_lat: got %0d want %0d", tr - t, lat_of(1));
    end
    n_cmp++;
    if (d !== exp_word(24'hFFFFFC) || cap_addr[1] !== 24'hFFFFFC) begin
      n_fail++; $display("FAIL div1_data: got %h@%h want %h@FFFFFC", d, cap_addr[1], exp_word(24'hFFFFFC));
    end
    wait_ready(1, trdy, to);
    $display("txn div1 u1 addr=FFFFFC data=%h lat=%0d", d, tr - t);
  endtask

  task automatic test_reset_mid();
    int t, tr, trdy, cnt0;
    bit to;
    logic [31:0] d;
    logic [23:0] a;
    a = 24'($urandom);
    fill_random(a);
    cnt0 = rsp_cnt[0];
    issue(0, a, 1'b0, t, to);
    repeat (74) @(negedge clock);
    n_cmp++;
    if ({flash_csb[0], flash_clk[0]} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_pre: got %b want 01", {flash_csb[0], flash_clk[0]});
    end
    resetb = 1'b0;
    #1;
    n_cmp++;
    if ({flash_csb[0], flash_clk[0]} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_async: got %b want 10", {flash_csb[0], flash_clk[0]});
    end
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    repeat (300) @(negedge clock);
    n_cmp++;
    if (rsp_cnt[0] != cnt0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d want 0", rsp_cnt[0] - cnt0); end
    n_cmp++;
    if ({req_ready[0], busy[0]} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_idle: got %b want 10", {req_ready[0], busy[0]});
    end
    a = 24'($urandom);
    fill_random(a);
    issue(0, a, 1'b0, t, to);
    wait_rsp(0, tr, d, to);
    n_cmp++;
    if (to || d !== exp_word(a) || (tr - t) != lat_of(0)) begin
      n_fail++; $display("FAIL rstmid_fresh: got %h lat %0d want %h lat %0d", d, tr - t, exp_word(a), lat_of(0));
    end
    wait_ready(0, trdy, to);
    $display("txn rstmid u0 addr=%h data=%h lat=%0d", a, d, tr - t);
  endtask

  task automatic test_busy_ignore();
    int t, tr, trdy, cnt0;
    bit to;
    logic [31:0] d;
    logic [23:0] a;
    a = 24'h0A5A50;
    fill_random(a);
    fill_random(24'h000200);
    cnt0 = rsp_cnt[0];
    issue(0, a, 1'b0, t, to);
    repeat (40) @(negedge clock);
    req_valid[0] = 1'b1;
    req_addr[0] = 24'h000200;
    @(negedge clock);
    req_valid[0] = 1'b0;
    wait_rsp(0, tr, d, to);
    n_cmp++;
    if (to || d !== exp_word(a) || cap_addr[0] !== a) begin
      n_fail++; $display("FAIL busy_first: got %h@%h want %h@%h", d, cap_addr[0], exp_word(a), a);
    end
    wait_ready(0, trdy, to);
    repeat (300) @(negedge clock);
    n_cmp++;
    if (rsp_cnt[0] - cnt0 != 1) begin n_fail++; $display("FAIL busy_one_rsp: got %0d want 1", rsp_cnt[0] - cnt0); end
    n_cmp++;
    if ({req_ready[0], busy[0], flash_csb[0]} !== 3'b101) begin
      n_fail++; $display("FAIL busy_idle_after: got %b want 101", {req_ready[0], busy[0], flash_csb[0]});
    end
    $display("txn busy u0 addr=%h data=%h", a, d);
  endtask

  task automatic test_random();
    int t, tr, trdy, u;
    bit to;
    logic [31:0] d;
    logic [23:0] a;
    for (int i = 0; i < 6; i++) begin
      u = i % 2;
      a = (i == 5) ? 24'hFFFFFE : 24'($urandom);
      fill_random(a);
      issue(u, a, 1'b0, t, to);
      wait_rsp(u, tr, d, to);
      n_cmp++;
      if (to || d !== exp_word(a)) begin
        n_fail++; $display("FAIL rand_data u%0d: got %h want %h", u, d, exp_word(a));
      end
      n_cmp++;
      if ({cap_cmd[u], cap_addr[u]} !== {CMD_EXP, a}) begin
        n_fail++; $display("FAIL rand_header u%0d: got %h want %h", u, {cap_cmd[u], cap_addr[u]}, {CMD_EXP, a});
      end
      n_cmp++;
      if ((tr - t) != lat_of(u)) begin
        n_fail++; $display("FAIL rand_lat u%0d: got %0d want %0d", u, tr - t, lat_of(u));
      end
      wait_ready(u, trdy, to);
      n_cmp++;
      if (to || (trdy - t) != lat_of(u) + 1 + CSB_IDLE) begin
        n_fail++; $display("FAIL rand_ready u%0d: got %0d want %0d", u, trdy - t, lat_of(u) + 1 + CSB_IDLE);
      end
      $display("txn rand u%0d addr=%h data=%h lat=%0d", u, a, d, tr - t);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0;
    n_cmp = 0;
    n_fail = 0;
    rsp_cnt[0] = 0;
    rsp_cnt[1] = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_clk_div1();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
